// File: rtl/tnn_pkg.sv
// Shared helpers for the temporal-neural-network column blocks.
//
// Purpose:
//   Width helpers and the packed-weight unpack function used by the RNL
//   neuron body and by the winner-take-all stage downstream.
//
// Contents:
//   pot_width     - bits needed to hold a body potential of n*wmax
//   time_width    - bits needed to count a gamma cycle of g cycles
//   unpack_weight - extract weight idx (w bits wide) from a packed vector
package tnn_pkg;

  // Upper bounds for the generic unpack helper; callers cast in and out.
  localparam int MAX_PACKED_W = 256;
  localparam int MAX_WEIGHT_W = 8;

  function automatic int pot_width(input int n, input int wmax);
    return $clog2(n * wmax + 1);
  endfunction

  function automatic int time_width(input int g);
    return $clog2(g);
  endfunction

  // Synapse idx lives at bits [idx*w +: w] of the packed vector.
  function automatic logic [MAX_WEIGHT_W-1:0] unpack_weight(
    input logic [MAX_PACKED_W-1:0] packed_w,
    input int                      idx,
    input int                      w
  );
    logic [MAX_WEIGHT_W-1:0] mask;
    mask = MAX_WEIGHT_W'((1 << w) - 1);
    return MAX_WEIGHT_W'(packed_w >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/rnl_ramp.sv
// Per-synapse ramp counter for the ramp-no-leak neuron.
//
// Purpose:
//   Counts how many potential units this synapse has contributed in the
//   current gamma cycle. While enabled and below its weight it requests one
//   unit per cycle; once the count reaches the weight the ramp is flat.
//   A paused input simply holds the count, so resumption continues from it.
//
// Ports:
//   aclk   in  clock, rising edge
//   rst    in  synchronous active-high reset, clears the count
//   clr    in  per-gamma clear (gamma-start strobe)
//   en     in  synapse input high and the neuron is armed this cycle
//   weight in  latched synapse weight (ramp cap); 0 disables the synapse
//   inc    out this synapse adds one unit to the potential on this edge
module rnl_ramp #(
  parameter int WEIGHT_WIDTH = 3
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  output logic                    inc
);

  logic [WEIGHT_WIDTH-1:0] ramp;

  // The cap compare also makes weight 0 a permanently silent synapse.
  assign inc = en && (ramp < weight);

  always_ff @(posedge aclk) begin
    if (rst) begin
      ramp <= '0;
    end else if (clr) begin
      ramp <= '0;
    end else if (inc) begin
      ramp <= ramp + 1'b1;
    end
  end

endmodule

// File: rtl/rnl_neuron.sv
// Ramp-no-leak temporal neuron body.
//
// Purpose:
//   Integrates a ramp-shaped response per synapse (one unit per cycle while
//   the synapse input is high, capped at its weight). The first time the
//   summed potential reaches the latched threshold within a gamma cycle the
//   neuron raises its race-logic output level, records the gamma-relative
//   spike time and emits a fixed-length fire pulse.
//
// Ports:
//   aclk       in  clock, rising edge
//   rst        in  synchronous active-high reset; clears state, disarms
//   grst       in  gamma-start strobe; latches weights/threshold, clears
//                  per-gamma state and arms the block
//   in         in  [NUM_INPUTS] spike levels from the delay stage
//   weights    in  [NUM_INPUTS*WEIGHT_WIDTH] packed synapse weights
//   threshold  in  [POT_W] firing threshold, 0 disables firing
//   out        out race-logic spike level, held until grst/rst
//   fire_pulse out high for PULSE_WIDTH cycles from the firing edge
//   spike_time out [TIME_W] gamma-relative firing cycle, valid while out=1
module rnl_neuron
  import tnn_pkg::*;
#(
  parameter  int NUM_INPUTS        = 8,
  parameter  int WEIGHT_WIDTH      = 3,
  parameter  int GAMMA_CYCLE_WIDTH = 128,
  parameter  int PULSE_WIDTH       = 8,
  localparam int WMAX              = (1 << WEIGHT_WIDTH) - 1,
  localparam int POT_W             = pot_width(NUM_INPUTS, WMAX),
  localparam int TIME_W            = time_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic                               aclk,
  input  logic                               rst,
  input  logic                               grst,
  input  logic [NUM_INPUTS-1:0]              in,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
  input  logic [POT_W-1:0]                   threshold,
  output logic                               out,
  output logic                               fire_pulse,
  output logic [TIME_W-1:0]                  spike_time
);

  localparam int INC_W  = $clog2(NUM_INPUTS + 1);
  localparam int PCNT_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [TIME_W-1:0] GAMMA_LAST = TIME_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PCNT_W-1:0] PULSE_LEN  = PCNT_W'(PULSE_WIDTH);

  // Control state
  logic                               armed;
  logic [TIME_W-1:0]                  gcnt;
  logic [PCNT_W-1:0]                  pulse_cnt;

  // Per-gamma latched configuration and accumulated potential
  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights_q;
  logic [POT_W-1:0]                   threshold_q;
  logic [POT_W-1:0]                   pot;

  // Combinational datapath
  logic [NUM_INPUTS-1:0]              inc;
  logic [INC_W-1:0]                   inc_cnt;
  logic [POT_W-1:0]                   pot_next;
  logic                               ramp_en_any;
  logic                               fire;

  // The grst cycle only reloads configuration; inputs sampled then are dropped.
  assign ramp_en_any = armed && !grst;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_syn
    logic [WEIGHT_WIDTH-1:0] w_i;

    assign w_i = WEIGHT_WIDTH'(unpack_weight(MAX_PACKED_W'(weights_q), i, WEIGHT_WIDTH));

    rnl_ramp #(
      .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_ramp (
      .aclk  (aclk),
      .rst   (rst),
      .clr   (grst),
      .en    (ramp_en_any && in[i]),
      .weight(w_i),
      .inc   (inc[i])
    );
  end

  // Popcount of per-synapse increments: at most NUM_INPUTS units per cycle.
  always_comb begin
    inc_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      inc_cnt = inc_cnt + INC_W'(inc[i]);
    end
  end

  // NUM_INPUTS*WMAX fits in POT_W, so this sum cannot wrap.
  assign pot_next = pot + POT_W'(inc_cnt);

  // Compare against the updated potential so a crossing fires on the same
  // edge that samples the input.
  assign fire = ramp_en_any && !out && (threshold_q != '0) &&
                (pot_next >= threshold_q);

  // ---- registered stage: control, potential, fire outputs ----
  always_ff @(posedge aclk) begin
    if (rst) begin
      armed       <= 1'b0;
      weights_q   <= '0;
      threshold_q <= '0;
      pot         <= '0;
      gcnt        <= '0;
      out         <= 1'b0;
      spike_time  <= '0;
      pulse_cnt   <= '0;
    end else if (grst) begin
      armed       <= 1'b1;
      weights_q   <= weights;
      threshold_q <= threshold;
      pot         <= '0;
      gcnt        <= '0;
      out         <= 1'b0;
      spike_time  <= '0;
      pulse_cnt   <= '0;
    end else if (armed) begin
      pot <= pot_next;
      if (gcnt != GAMMA_LAST) begin
        gcnt <= gcnt + 1'b1;
      end
      if (fire) begin
        out        <= 1'b1;
        spike_time <= gcnt;
        pulse_cnt  <= PULSE_LEN;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end
  end

  assign fire_pulse = (pulse_cnt != '0);

endmodule

// File: tb/tb_rnl_neuron.sv
// Scoreboarded directed bench for rnl_neuron.
module tb_rnl_neuron;

  localparam int N      = 8;
  localparam int WW     = 3;
  localparam int G      = 128;
  localparam int PW     = 8;
  localparam int POT_W  = 6;
  localparam int TIME_W = 7;

  logic              aclk = 1'b0;
  logic              rst;
  logic              grst;
  logic [N-1:0]      in_s;
  logic [N*WW-1:0]   weights;
  logic [POT_W-1:0]  threshold;
  logic              out_s;
  logic              fire_pulse;
  logic [TIME_W-1:0] spike_time;

  always #5 aclk = ~aclk;

  rnl_neuron #(
    .NUM_INPUTS       (N),
    .WEIGHT_WIDTH     (WW),
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH      (PW)
  ) dut (
    .aclk      (aclk),
    .rst       (rst),
    .grst      (grst),
    .in        (in_s),
    .weights   (weights),
    .threshold (threshold),
    .out       (out_s),
    .fire_pulse(fire_pulse),
    .spike_time(spike_time)
  );

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected firing events: spike time, pulse length seen, edge count of fire.
  typedef struct {
    int t;
    int len;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: pops an expectation on every rising edge of out and measures
  // the fire_pulse length that follows.
  logic out_d = 1'b0;
  int   trk   = 0;
  int   plen  = 0;
  int   elen  = 0;
  exp_t e_m;

  always @(negedge aclk) begin
    if (out_s && !out_d) begin
      if (sb.size() == 0) begin
        chk("unexpected_fire", 1, 0);
        elen = PW;
      end else begin
        e_m = sb.pop_front();
        chk("spike_time", int'(spike_time), e_m.t);
        chk("fire_cycle", cyc, e_m.cyc);
        elen = e_m.len;
      end
      trk  = 1;
      plen = 0;
    end
    if (trk != 0) begin
      if (fire_pulse) begin
        plen++;
      end else begin
        chk("pulse_len", plen, elen);
        trk = 0;
      end
    end
    out_d = out_s;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic push(input int t, input int len, input int c);
    exp_t e;
    e.t   = t;
    e.len = len;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Returns the edge count at the grst edge (edge E0 of the new gamma).
  task automatic do_grst(output int g);
    grst = 1'b1;
    tick(1);
    grst = 1'b0;
    g = cyc;
  endtask

  int g;

  initial begin
    rst       = 1'b1;
    grst      = 1'b0;
    in_s      = '0;
    weights   = {N{3'd7}};
    threshold = 6'd1;

    // Reset state
    tick(3);
    chk("rst_out", int'(out_s), 0);
    chk("rst_fire_pulse", int'(fire_pulse), 0);
    chk("rst_spike_time", int'(spike_time), 0);
    chk("rst_pot", int'(dut.pot), 0);

    // Not armed: inputs ignored
    rst  = 1'b0;
    in_s = '1;
    tick(20);
    chk("unarmed_out", int'(out_s), 0);
    chk("unarmed_fire_pulse", int'(fire_pulse), 0);
    chk("unarmed_pot", int'(dut.pot), 0);

    // Weights 3, threshold 3, in[0] first sampled on E6 -> fire on E8, time 7
    in_s      = '0;
    weights   = {N{3'd3}};
    threshold = 6'd3;
    do_grst(g);
    tick(5);
    in_s = 8'h01;
    push(7, PW, g + 8);
    tick(20);
    chk("w3_pot_capped", int'(dut.pot), 3);

    // Weights 7, threshold 8, two inputs from E3 -> 2,4,6,8 -> fire E6, time 5
    in_s      = '0;
    weights   = {N{3'd7}};
    threshold = 6'd8;
    do_grst(g);
    tick(2);
    in_s = 8'h03;
    push(5, PW, g + 6);
    tick(15);
    chk("w7_two_pot", int'(dut.pot), 14);

    // One input, cap 7 < threshold 8 -> never fires
    in_s = 8'h01;
    do_grst(g);
    tick(20);
    chk("w7_one_pot", int'(dut.pot), 7);
    chk("w7_one_out", int'(out_s), 0);

    // Threshold 0 disables firing
    in_s      = '1;
    threshold = 6'd0;
    do_grst(g);
    tick(12);
    chk("thr0_pot", int'(dut.pot), 56);
    chk("thr0_out", int'(out_s), 0);

    // Weight 0 on the only active synapse
    in_s      = 8'h01;
    weights   = {{(N-1){3'd7}}, 3'd0};
    threshold = 6'd1;
    do_grst(g);
    tick(10);
    chk("w0_pot", int'(dut.pot), 0);
    chk("w0_out", int'(out_s), 0);

    // Fire on E3 (time 2), grst sampled on E5 truncates the pulse to 2 cycles,
    // then the new gamma fires again three edges later.
    in_s      = 8'h01;
    weights   = {N{3'd3}};
    threshold = 6'd3;
    push(2, 2, cyc + 1 + 3);
    do_grst(g);
    tick(3);
    chk("abort_pre_out", int'(out_s), 1);
    tick(1);
    push(2, PW, g + 5 + 3);
    grst = 1'b1;
    tick(1);
    grst = 1'b0;
    chk("abort_out", int'(out_s), 0);
    chk("abort_fire_pulse", int'(fire_pulse), 0);
    chk("abort_spike_time", int'(spike_time), 0);
    chk("abort_pot", int'(dut.pot), 0);
    tick(15);

    // rst and grst together: rst wins, block stays disarmed
    in_s      = '1;
    weights   = {N{3'd7}};
    threshold = 6'd1;
    rst       = 1'b1;
    grst      = 1'b1;
    tick(1);
    rst  = 1'b0;
    grst = 1'b0;
    chk("rstgrst_armed", int'(dut.armed), 0);
    tick(10);
    chk("rstgrst_out", int'(out_s), 0);
    chk("rstgrst_pot", int'(dut.pot), 0);

    // A later grst arms it: fire on E1, time 0
    push(0, PW, cyc + 1 + 1);
    do_grst(g);
    tick(12);

    // Gamma counter saturation: input first sampled on E141 -> time 127
    in_s = '0;
    do_grst(g);
    tick(140);
    in_s = 8'h01;
    push(G - 1, PW, g + 141);
    tick(12);

    tick(2);
    chk("sb_empty", sb.size(), 0);
    chk("pulse_tracking_done", trk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rnl_neuron.md
# rnl_neuron

Ramp-no-leak (RNL) temporal neuron body that consumes the per-synapse spike levels produced by the delay/memory stage (`mem`) directly upstream. Within each gamma cycle it integrates a ramp-shaped response per input, capped at the synapse weight. When the summed body potential first reaches the threshold, it emits a race-logic output spike (a level held until the next gamma start) and records the spike time. It sits between the synapse delay stage and the column's winner-take-all/inhibition stage.

## Interface
- `NUM_INPUTS`, 8, number of synapses.
- `WEIGHT_WIDTH`, 3, bits per weight; max weight `WMAX = 2**WEIGHT_WIDTH-1`.
- `GAMMA_CYCLE_WIDTH`, 128, cycles per gamma cycle (power of 2).
- `PULSE_WIDTH`, 8, length in cycles of `fire_pulse`.
- Derived: `POT_W = $clog2(NUM_INPUTS*WMAX+1)`, `TIME_W = $clog2(GAMMA_CYCLE_WIDTH)`.

Ports:
- `aclk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high; all state cleared, block disarmed.
- `grst`  in  1  gamma-start strobe (one cycle, synchronous); clears per-gamma state and arms the block.
- `in`  in  NUM_INPUTS  spike levels from upstream; a 0→1 edge marks the spike; the level stays high until the next gamma.
- `weights`  in  NUM_INPUTS*WEIGHT_WIDTH  packed weights, synapse i at bits [i*W +: W].
- `threshold`  in  POT_W  firing threshold.
- `out`  out  1  race-logic spike level; rises at firing, held until `grst`/`rst`.
- `fire_pulse`  out  1  high for PULSE_WIDTH cycles starting at firing.
- `spike_time`  out  TIME_W  gamma-relative cycle of firing; valid while `out`=1.

## Operation
- Reset values: `out`=0, `fire_pulse`=0, `spike_time`=0; potential, ramp counters, gamma counter and pulse counter are 0; `armed`=0.
- On a `grst` cycle:
  - latch `weights` and `threshold`;
  - clear the potential, all ramp counters, `out`, `spike_time` and the pulse counter;
  - set gamma counter=0 and `armed`=1;
  - ignore `in` that cycle.
- Each armed cycle without `grst`:
  - For every synapse i with `in[i]`=1 and `ramp[i]` < `w_i`: `ramp[i]`++ and the potential gains 1. At most NUM_INPUTS is added per cycle.
  - Weight 0 means the synapse never contributes.
  - The gamma counter increments, saturating at GAMMA_CYCLE_WIDTH-1.
- Firing:
  - If `out`=0 and the updated potential ≥ latched threshold (latched threshold ≠ 0), then on that edge set `out`=1, `spike_time` = gamma counter value before increment, and start `fire_pulse`.
  - Threshold 0 means the neuron is disabled and never fires.
  - At most one fire per gamma; the potential keeps accumulating after firing.
  - The potential cannot overflow: its maximum, NUM_INPUTS*WMAX, fits in POT_W.
- Not armed (after `rst`, before the first `grst`): inputs are ignored and all state is held.
- `in` is treated as a level. A synapse dropping to 0 pauses its ramp, and resumption continues from the held count.

## Timing
- Latency: if `in[i]` is first sampled high at edge k and that increment crosses threshold, `out`, `fire_pulse` and `spike_time` are visible after edge k (1-cycle registered path from `in`).
- `fire_pulse` is high for exactly PULSE_WIDTH cycles. A `grst` mid-pulse truncates it to 0 on the next edge.
- `rst` and `grst` asserted together: `rst` wins, and the block ends disarmed.
- `grst` while firing or ramping aborts the current gamma with no carry-over; the new gamma starts clean next cycle.
- Gamma counter saturation: `spike_time` for late fires reads GAMMA_CYCLE_WIDTH-1.

## Structure
- Shared package `tnn_pkg`: `POT_W`/`TIME_W` helper functions (clog2 of the max potential) and the weight-unpack function; these are reused by the WTA stage.
- Sub-module `rnl_ramp` is instantiated NUM_INPUTS times:
  - holds a WEIGHT_WIDTH ramp counter;
  - inputs `aclk`, `rst`, `clr`, `en`, `weight`;
  - outputs a 1-bit `inc`.
- The top holds the popcount adder over the `inc` bits, the potential register, the gamma counter, the fire logic and the pulse counter.

## Test plan
- Reset then no `grst`, `in`=all 1 for 20 cycles → `out`=0, potential 0, `fire_pulse`=0.
- `grst`; weights all 3; threshold 3; `in[0]` rises 5 cycles after `grst` → `out` rises after the 3rd sampled-high edge, `spike_time`=7, `fire_pulse` high 8 cycles.
- `grst`; weights all 7; threshold 8; `in[0]`,`in[1]` rise the same cycle → potential +2 per cycle, fire on the 4th increment edge; `in[0]` alone with threshold 8 → never fires (cap 7).
- Threshold 0 with all inputs high, and weight 0 on the only active synapse with threshold 1 → `out` never rises.
- `grst` asserted 2 cycles after firing (mid-pulse) → `out`, `fire_pulse`, `spike_time` return to 0 next edge; a second gamma fires again at the correct time.
- `rst` and `grst` in the same cycle with `in` high → block disarmed, no firing until a later `grst`.
